// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t    : fetch FSM states
//   NOP_INSTR        : bubble instruction (addi x0, x0, 0)
//   RESET_PC_DEFAULT : default fetch address after reset
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // presenting a request to instruction memory
        S_WAIT = 2'd1,  // request accepted, waiting for read data
        S_HOLD = 2'd2,  // data returned while Decode stalled; parked in BufF
        S_DROP = 2'd3   // redirect arrived before data; discard the stale response
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipeline_fd.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset (async, active-low)
//   flush    : load a bubble (highest priority)
//   stall    : hold current contents
//   load     : capture instr/pc/pc_plus4 as a valid instruction
//   instr, pc, pc_plus4 : data to capture on load
//   instr_d, pc_d, pc_plus4_d, valid_d : register contents seen by Decode
// With none of flush/stall/load asserted a bubble is loaded. A bubble
// replaces the instruction with a NOP and clears valid_d but keeps the PC
// fields, so Decode always sees the PC of the last real instruction.
module pipeline_fd
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= 32'd0;
            pc_plus4_d <= 32'd0;
            valid_d    <= 1'b0;
        end else if (flush) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end else if (stall) begin
            instr_d    <= instr_d;
            pc_d       <= pc_d;
            pc_plus4_d <= pc_plus4_d;
            valid_d    <= valid_d;
        end else if (load) begin
            instr_d    <= instr;
            pc_d       <= pc;
            pc_plus4_d <= pc_plus4;
            valid_d    <= 1'b1;
        end else begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register for the pipelined RV32 core.
// Owns the fetch PC, issues one outstanding request at a time to
// instruction memory (req/ready, then rvalid), handles redirects from
// Execute and feeds Decode.
// Ports:
//   clk, reset (async, active-low)
//   StallD, FlushD         : hazard unit controls for IF/ID
//   PCSrcE, PCTargetE      : redirect request and target from Execute
//   ImemReq, ImemAddr      : request valid / address (address is always PCF)
//   ImemReady              : memory accepts the request this cycle
//   ImemRvalid, ImemRdata  : read response
//   InstrD, PCD, PCPlus4D, ValidD : IF/ID contents
//   opD, funct3D, funct7b5D: instruction fields for the controller
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [6:0]  opD,
    output logic [2:0]  funct3D,
    output logic        funct7b5D
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pcf_reg, pcf_next;
    logic [31:0]  buf_reg, buf_next;

    logic         deliver;
    logic [31:0]  deliver_data;
    logic [31:0]  pcf_plus4;
    logic [31:0]  redirect_pc;

    assign pcf_plus4   = pcf_reg + 32'd4;
    // Instructions are word aligned; drop any low bits of the target.
    assign redirect_pc = {PCTargetE[31:2], 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_REQ;
            pcf_reg   <= RESET_PC;
            buf_reg   <= NOP_INSTR;
        end else begin
            state_reg <= state_next;
            pcf_reg   <= pcf_next;
            buf_reg   <= buf_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pcf_next     = pcf_reg;
        buf_next     = buf_reg;
        deliver      = 1'b0;
        deliver_data = buf_reg;

        unique case (state_reg)
            S_REQ: begin
                if (PCSrcE) begin
                    pcf_next = redirect_pc;
                end else if (ImemReady) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    pcf_next   = redirect_pc;
                    // Data already here can simply be ignored; otherwise the
                    // response is still in flight and must be swallowed later.
                    state_next = ImemRvalid ? S_REQ : S_DROP;
                end else if (ImemRvalid) begin
                    if (!StallD) begin
                        deliver      = 1'b1;
                        deliver_data = ImemRdata;
                        pcf_next     = pcf_plus4;
                        state_next   = S_REQ;
                    end else begin
                        buf_next   = ImemRdata;
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    pcf_next   = redirect_pc;
                    state_next = S_REQ;
                end else if (!StallD) begin
                    deliver      = 1'b1;
                    deliver_data = buf_reg;
                    pcf_next     = pcf_plus4;
                    state_next   = S_REQ;
                end
            end
            S_DROP: begin
                if (PCSrcE) begin
                    pcf_next = redirect_pc;
                end
                if (ImemRvalid) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // Gating with reset keeps the request low while reset is held, even
    // though the state register already reads S_REQ.
    assign ImemReq  = reset && (state_reg == S_REQ) && !PCSrcE;
    assign ImemAddr = pcf_reg;

    // FlushD during a delivery still lets the FSM consume the data and
    // advance PCF above; only the IF/ID register takes the bubble.
    pipeline_fd u_pipeline_fd (
        .clk        (clk),
        .reset      (reset),
        .flush      (FlushD),
        .stall      (StallD),
        .load       (deliver),
        .instr      (deliver_data),
        .pc         (pcf_reg),
        .pc_plus4   (pcf_plus4),
        .instr_d    (InstrD),
        .pc_d       (PCD),
        .pc_plus4_d (PCPlus4D),
        .valid_d    (ValidD)
    );

    assign opD       = InstrD[6:0];
    assign funct3D   = InstrD[14:12];
    assign funct7b5D = InstrD[30];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a responding instruction memory,
// a scoreboard of expected deliveries and directed scenarios.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [6:0]  opD;
    logic [2:0]  funct3D;
    logic        funct7b5D;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemReady  (ImemReady),
        .ImemRvalid (ImemRvalid),
        .ImemRdata  (ImemRdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .opD        (opD),
        .funct3D    (funct3D),
        .funct7b5D  (funct7b5D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h0050_0093;
        return (a << 10) ^ 32'h4000_2033;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        exp_q.push_back(e);
    endtask

    // Memory responder: single outstanding request, 1 + lat_extra cycles.
    int          lat_extra = 0;
    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend       <= 1'b0;
            pend_addr  <= 32'd0;
            cnt        <= 0;
            ImemRvalid <= 1'b0;
            ImemRdata  <= 32'd0;
        end else begin
            ImemRvalid <= 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    ImemRvalid <= 1'b1;
                    ImemRdata  <= mem_word(pend_addr);
                    pend       <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (ImemReq && ImemReady) begin
                pend      <= 1'b1;
                pend_addr <= ImemAddr;
                cnt       <= lat_extra;
            end
        end
    end

    // Delivery monitor: a new instruction is a valid IF/ID entry that
    // either follows a bubble or carries a different PC.
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pcd   = 32'd0;

    always @(posedge clk) begin
        #1;
        if (ValidD && (!prev_valid || PCD != prev_pcd)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_delivery_pc", PCD, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("deliver pc=%08h instr=%08h (expect pc=%08h instr=%08h)",
                         PCD, InstrD, e.pc, e.instr);
                chk("InstrD",    InstrD,              e.instr);
                chk("PCD",       PCD,                 e.pc);
                chk("PCPlus4D",  PCPlus4D,            e.pc + 32'd4);
                chk("opD",       32'(opD),            32'(e.instr[6:0]));
                chk("funct3D",   32'(funct3D),        32'(e.instr[14:12]));
                chk("funct7b5D", 32'(funct7b5D),      32'(e.instr[30]));
            end
        end
        prev_valid = ValidD;
        prev_pcd   = PCD;
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_req(input logic [31:0] addr);
        int n = 0;
        while (!(ImemReq && ImemAddr == addr) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_req_addr", ImemAddr, addr);
    endtask

    task automatic wait_rvalid();
        int n = 0;
        while (!ImemRvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_rvalid", 32'(ImemRvalid), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ImemReq"},  32'(ImemReq), 32'd0);
        chk({tag, "_ImemAddr"}, ImemAddr,     32'd0);
        chk({tag, "_InstrD"},   InstrD,       32'h0000_0013);
        chk({tag, "_PCD"},      PCD,          32'd0);
        chk({tag, "_PCPlus4D"}, PCPlus4D,     32'd0);
        chk({tag, "_ValidD"},   32'(ValidD),  32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'd0;
        ImemReady = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");

        // Reset release and first fetches
        push_exp(32'd0);
        push_exp(32'd4);
        reset = 1'b1;
        #1;
        chk("first_ImemReq",  32'(ImemReq), 32'd1);
        chk("first_ImemAddr", ImemAddr,     32'd0);
        drain();
        chk("after4_ImemAddr", ImemAddr, 32'd8);

        // Stall while the response at PC 8 returns
        push_exp(32'd8);
        wait_req(32'd8);
        @(negedge clk);
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ImemReq", 32'(ImemReq), 32'd0);
            chk("stall_InstrD",  InstrD,       32'h0000_0013);
            chk("stall_ValidD",  32'(ValidD),  32'd0);
            chk("stall_PCD",     PCD,          32'd4);
        end
        StallD = 1'b0;
        drain();

        // Redirect while waiting for PC 12; stale response must be dropped
        wait_req(32'd12);
        lat_extra = 1;
        @(negedge clk);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0100;
        chk("redir_ImemReq", 32'(ImemReq), 32'd0);
        @(negedge clk);
        PCSrcE    = 1'b0;
        lat_extra = 0;
        chk("redir_ValidD",   32'(ValidD), 32'd0);
        chk("redir_ImemAddr", ImemAddr,    32'h0000_0100);
        push_exp(32'h0000_0100);
        wait_req(32'h0000_0100);
        drain();

        // Flush and stall together: flush wins
        FlushD = 1'b1;
        StallD = 1'b1;
        @(negedge clk);
        FlushD = 1'b0;
        StallD = 1'b0;
        chk("flush_InstrD", InstrD,      32'h0000_0013);
        chk("flush_ValidD", 32'(ValidD), 32'd0);
        chk("flush_PCD",    PCD,         32'h0000_0100);
        push_exp(32'h0000_0104);
        drain();

        // Flush during delivery of 0x108: bubble, but PCF still advances
        wait_rvalid();
        FlushD = 1'b1;
        @(negedge clk);
        FlushD = 1'b0;
        chk("fdeliv_ValidD",   32'(ValidD),  32'd0);
        chk("fdeliv_InstrD",   InstrD,       32'h0000_0013);
        chk("fdeliv_PCD",      PCD,          32'h0000_0104);
        chk("fdeliv_ImemAddr", ImemAddr,     32'h0000_010C);
        chk("fdeliv_ImemReq",  32'(ImemReq), 32'd1);

        // Backpressure on 0x10C
        ImemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ImemReq",  32'(ImemReq), 32'd1);
            chk("bp_ImemAddr", ImemAddr,     32'h0000_010C);
        end
        ImemReady = 1'b1;
        push_exp(32'h0000_010C);
        drain();

        // Redirect in S_REQ to an unaligned target near the top of memory
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFFE;
        #1;
        chk("wrap_withdraw_ImemReq", 32'(ImemReq), 32'd0);
        @(negedge clk);
        PCSrcE = 1'b0;
        chk("wrap_ImemAddr", ImemAddr, 32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC);
        drain();
        chk("wrap_next_ImemAddr", ImemAddr,     32'd0);
        chk("wrap_next_ImemReq",  32'(ImemReq), 32'd1);

        // Reset with a request outstanding
        @(negedge clk);
        chk("rstw_waiting_ImemReq", 32'(ImemReq), 32'd0);
        reset = 1'b0;
        #1;
        chk_reset_outputs("rstw");
        repeat (2) @(negedge clk);
        chk_reset_outputs("rstw_hold");
        push_exp(32'd0);
        reset = 1'b1;
        #1;
        chk("rstw_rel_ImemReq", 32'(ImemReq), 32'd1);
        drain();
        chk("rstw_next_ImemAddr", ImemAddr, 32'd4);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
